sdp_ram: RTL and testbench



---
 rtl/sdp_ram.sv | 104 ++++++++++
 tb/tb_sdp_ram.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/sdp_ram.sv
// -----------------------------------------------------------------------------
// sdp_ram
//
// Simple dual-port synchronous RAM: one write port and one read port sharing
// a single clock, with a registered read data output. Used as the storage
// element underneath the FIFOs. Word width and depth are parameterised; the
// depth need not be a power of two.
//
// Parameters:
//   WIDTH  - data word width in bits
//   SIZE   - number of words
//   ABITS  - address width, $clog2(SIZE) with a minimum of 1 (derived)
//
// Ports:
//   clk     in   1      single clock, all state updates on its rising edge
//   rst_n   in   1      asynchronous active-low reset (clears rddata only)
//   rden    in   1      read enable
//   rdaddr  in   ABITS  read address
//   rddata  out  WIDTH  registered read data
//   wren    in   1      write enable
//   wraddr  in   ABITS  write address
//   wrdata  in   WIDTH  write data
//
// Behaviour summary:
//   - Writes to addresses >= SIZE are dropped.
//   - Reads from addresses >= SIZE load all zeros.
//   - A read and write to the same address on the same edge: the write lands,
//     the read is suppressed and rddata keeps its previous value.
//   - While rst_n is low rddata is forced to zero and both ports are ignored;
//     the array contents survive reset.
// -----------------------------------------------------------------------------
module sdp_ram #(
    parameter  int WIDTH = 64,
    parameter  int SIZE  = 1024,
    localparam int ABITS = (SIZE > 1) ? $clog2(SIZE) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rden,
    input  logic [ABITS-1:0] rdaddr,
    output logic [WIDTH-1:0] rddata,
    input  logic             wren,
    input  logic [ABITS-1:0] wraddr,
    input  logic [WIDTH-1:0] wrdata
);

    // SIZE expressed one bit wider than an address so that the range check
    // stays exact when SIZE is a power of two.
    localparam logic [ABITS:0] SIZE_W = (ABITS + 1)'(SIZE);

    logic [WIDTH-1:0] mem_q [SIZE];
    logic [WIDTH-1:0] rddata_q;
    logic [WIDTH-1:0] rddata_d;

    logic wr_in_range;
    logic rd_in_range;
    logic collision;
    logic wr_fire;

    assign wr_in_range = ({1'b0, wraddr} < SIZE_W);
    assign rd_in_range = ({1'b0, rdaddr} < SIZE_W);

    // Same-address collision: the write wins, the read is suppressed.
    assign collision = rden && wren && (rdaddr == wraddr);

    // Writes are ignored while reset is held low.
    assign wr_fire = rst_n && wren && wr_in_range;

    // NOTE: the storage array has no reset so it maps onto block RAM; only the
    // output register below is reset.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_q[wraddr] <= wrdata;
        end
    end

    // Next value of the output register. Out-of-range reads return zeros and
    // never index the array.
    always_comb begin
        // NOTE: default assignment first so no path leaves rddata_d unassigned,
        // which would otherwise infer a latch.
        rddata_d = rddata_q;
        if (rden && !collision) begin
            if (rd_in_range) begin
                rddata_d = mem_q[rdaddr];
            end else begin
                rddata_d = '0;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs as they were before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rddata_q <= '0;
        end else begin
            rddata_q <= rddata_d;
        end
    end

    assign rddata = rddata_q;

endmodule

// File: tb/tb_sdp_ram.sv
// -----------------------------------------------------------------------------
// tb_sdp_ram
//
// Drives two sdp_ram instances with identical stimulus: one 1024 words deep
// (power-of-two depth, every address in range) and one 1000 words deep (the
// top 24 addresses out of range). A behavioural model holds the expected
// array contents and the expected read register for each instance.
// -----------------------------------------------------------------------------
module tb_sdp_ram;

    localparam int W      = 64;
    localparam int SIZE_A = 1024;
    localparam int SIZE_B = 1000;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b1;
    logic         rden  = 1'b0;
    logic [9:0]   rdaddr = '0;
    logic         wren  = 1'b0;
    logic [9:0]   wraddr = '0;
    logic [W-1:0] wrdata = '0;
    logic [W-1:0] rddata_a;
    logic [W-1:0] rddata_b;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    sdp_ram #(.WIDTH(W), .SIZE(SIZE_A)) dut_a (
        .clk    (clk),
        .rst_n  (rst_n),
        .rden   (rden),
        .rdaddr (rdaddr),
        .rddata (rddata_a),
        .wren   (wren),
        .wraddr (wraddr),
        .wrdata (wrdata)
    );

    sdp_ram #(.WIDTH(W), .SIZE(SIZE_B)) dut_b (
        .clk    (clk),
        .rst_n  (rst_n),
        .rden   (rden),
        .rdaddr (rdaddr),
        .rddata (rddata_b),
        .wren   (wren),
        .wraddr (wraddr),
        .wrdata (wrdata)
    );

    // ---------------------------------------------------------------------
    // Reference model: plain arrays plus a "written" flag per word, since the
    // array contents are undefined until first written.
    // ---------------------------------------------------------------------
    logic [W-1:0] mem_a [SIZE_A];
    logic [W-1:0] mem_b [SIZE_B];
    bit           val_a [SIZE_A];
    bit           val_b [SIZE_B];
    logic [W-1:0] exp_a = '0;
    logic [W-1:0] exp_b = '0;
    bit           kn_a  = 1'b0;
    bit           kn_b  = 1'b0;

    task automatic check(input string name, input logic [W-1:0] act,
                         input logic [W-1:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    task automatic model_edge(input logic re, input logic [9:0] ra,
                              input logic we, input logic [9:0] wa,
                              input logic [W-1:0] wd);
        if (!rst_n) begin
            exp_a = '0; kn_a = 1'b1;
            exp_b = '0; kn_b = 1'b1;
            return;
        end
        // Read sees the contents from before this edge; a same-address
        // read+write leaves the previous read value in place.
        if (re && !(we && wa == ra)) begin
            exp_a = mem_a[ra];
            kn_a  = val_a[ra];
            if (int'(ra) < SIZE_B) begin
                exp_b = mem_b[ra];
                kn_b  = val_b[ra];
            end else begin
                exp_b = '0;
                kn_b  = 1'b1;
            end
        end
        if (we) begin
            mem_a[wa] = wd;
            val_a[wa] = 1'b1;
            if (int'(wa) < SIZE_B) begin
                mem_b[wa] = wd;
                val_b[wa] = 1'b1;
            end
        end
    endtask

    // One clock cycle: drive inputs away from the edge, let the edge happen,
    // update the model, then sample the outputs 1 time unit after the edge.
    task automatic step(input string name, input logic re, input logic [9:0] ra,
                        input logic we, input logic [9:0] wa,
                        input logic [W-1:0] wd);
        rden   = re;
        rdaddr = ra;
        wren   = we;
        wraddr = wa;
        wrdata = wd;
        @(posedge clk);
        model_edge(re, ra, we, wa, wd);
        #1;
        if (kn_a) check({name, "/model_a"}, rddata_a, exp_a);
        if (kn_b) check({name, "/model_b"}, rddata_b, exp_b);
    endtask

    // ---------------------------------------------------------------------
    // Directed vector table
    // ---------------------------------------------------------------------
    typedef struct {
        string        name;
        logic         re;
        logic [9:0]   ra;
        logic         we;
        logic [9:0]   wa;
        logic [W-1:0] wd;
        logic         chk;
        logic [W-1:0] exp;
    } vec_t;

    localparam int NVEC = 11;
    vec_t vecs [NVEC];

    initial begin
        vecs[0]  = '{"wr5_no_read",   1'b0, 10'd0,  1'b1, 10'd5,  64'hDEADBEEF_00000001, 1'b1, 64'h0};
        vecs[1]  = '{"rd5",           1'b1, 10'd5,  1'b0, 10'd0,  64'h0,                 1'b1, 64'hDEADBEEF_00000001};
        vecs[2]  = '{"rd_hold",       1'b0, 10'd0,  1'b0, 10'd0,  64'h0,                 1'b1, 64'hDEADBEEF_00000001};
        vecs[3]  = '{"wr7_aa",        1'b0, 10'd0,  1'b1, 10'd7,  64'hAA,                1'b0, 64'h0};
        vecs[4]  = '{"wr3_33",        1'b0, 10'd0,  1'b1, 10'd3,  64'h33,                1'b0, 64'h0};
        vecs[5]  = '{"rd3",           1'b1, 10'd3,  1'b0, 10'd0,  64'h0,                 1'b1, 64'h33};
        vecs[6]  = '{"collide7",      1'b1, 10'd7,  1'b1, 10'd7,  64'hBB,                1'b1, 64'h33};
        vecs[7]  = '{"rd7_after",     1'b1, 10'd7,  1'b0, 10'd0,  64'h0,                 1'b1, 64'hBB};
        vecs[8]  = '{"wr9_99",        1'b0, 10'd0,  1'b1, 10'd9,  64'h99,                1'b0, 64'h0};
        vecs[9]  = '{"rd9_wr10",      1'b1, 10'd9,  1'b1, 10'd10, 64'h11,                1'b1, 64'h99};
        vecs[10] = '{"rd10",          1'b1, 10'd10, 1'b0, 10'd0,  64'h0,                 1'b1, 64'h11};

        // ---------------- reset ----------------
        #2 rst_n = 1'b0;
        #1;
        check("reset_async_a", rddata_a, 64'h0);
        check("reset_async_b", rddata_b, 64'h0);
        for (int i = 0; i < 3; i++) begin
            step("reset_rden", 1'b1, 10'd5, 1'b0, 10'd0, 64'h0);
            check("reset_hold_a", rddata_a, 64'h0);
            check("reset_hold_b", rddata_b, 64'h0);
        end
        rst_n = 1'b1;

        // ---------------- directed table ----------------
        for (int i = 0; i < NVEC; i++) begin
            step(vecs[i].name, vecs[i].re, vecs[i].ra, vecs[i].we,
                 vecs[i].wa, vecs[i].wd);
            if (vecs[i].chk) begin
                check({vecs[i].name, "/a"}, rddata_a, vecs[i].exp);
                check({vecs[i].name, "/b"}, rddata_b, vecs[i].exp);
            end
        end

        // ---------------- full-address sweep ----------------
        for (int i = 0; i < SIZE_A; i++) begin
            step("sweep_wr", 1'b0, 10'd0, 1'b1, 10'(i), 64'(i));
        end
        for (int i = SIZE_A - 1; i >= 0; i--) begin
            step("sweep_rd", 1'b1, 10'(i), 1'b0, 10'd0, 64'h0);
            check("sweep_a", rddata_a, 64'(i));
            check("sweep_b", rddata_b, (i < SIZE_B) ? 64'(i) : 64'h0);
        end

        // ---------------- mid-operation reset ----------------
        step("wr2_55", 1'b0, 10'd0, 1'b1, 10'd2, 64'h55);
        step("rd2_pre", 1'b1, 10'd2, 1'b0, 10'd0, 64'h0);
        check("rd2_pre_a", rddata_a, 64'h55);
        #2 rst_n = 1'b0;
        #1;
        exp_a = '0; kn_a = 1'b1;
        exp_b = '0; kn_b = 1'b1;
        check("midreset_async_a", rddata_a, 64'h0);
        check("midreset_async_b", rddata_b, 64'h0);
        // An edge with both ports active while reset is held must do nothing.
        step("midreset_edge", 1'b1, 10'd2, 1'b1, 10'd2, 64'h77);
        check("midreset_edge_a", rddata_a, 64'h0);
        rst_n = 1'b1;
        step("rd2_post", 1'b1, 10'd2, 1'b0, 10'd0, 64'h0);
        check("rd2_post_a", rddata_a, 64'h55);
        check("rd2_post_b", rddata_b, 64'h55);
        step("rd1010", 1'b1, 10'd1010, 1'b0, 10'd0, 64'h0);
        check("rd1010_a", rddata_a, 64'd1010);
        check("rd1010_b", rddata_b, 64'h0);
        step("wr1010", 1'b0, 10'd0, 1'b1, 10'd1010, 64'hABC);
        step("rd1010_again", 1'b1, 10'd1010, 1'b0, 10'd0, 64'h0);
        check("rd1010_again_a", rddata_a, 64'hABC);
        check("rd1010_again_b", rddata_b, 64'h0);

        // ---------------- randomized traffic ----------------
        // Narrow address windows keep collisions frequent and exercise the
        // out-of-range region of the 1000-word instance.
        for (int i = 0; i < 1500; i++) begin
            logic         re, we;
            logic [9:0]   ra, wa;
            logic [W-1:0] wd;
            re = 1'($urandom);
            we = 1'($urandom);
            ra = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(990, 1023))
                                             : 10'($urandom_range(0, 15));
            wa = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(990, 1023))
                                             : 10'($urandom_range(0, 15));
            wd = {$urandom, $urandom};
            step("random", re, ra, we, wa, wd);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
